// File: rtl/parking_input_conditioner.sv
// rtl/parking_input_conditioner.sv - sync/debounce raw buttons and switches into spaced car_enter/car_exit requests
// Optional 2-flop input synchronisers are enabled by defining PARKING_INPUT_SYNC_EN.
module parking_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLDOFF_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_enter_raw,
  input  logic       btn_exit_raw,
  input  logic [2:0] sw_sel_raw,
  output logic       car_enter,
  output logic       car_exit,
  output logic [2:0] car_sel,
  output logic       sel_error,
  output logic       busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]    HOLD_MAX = 8'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE_ENTER, ISSUE_EXIT, HOLDOFF} state_t;

  logic [4:0] raw;
  logic [4:0] synced;
  logic [4:0] deb;
  logic [CW-1:0] cnt [5];
  logic [1:0] btn_d;
  logic       enter_pend;
  logic       exit_pend;
  logic [7:0] hcnt;
  state_t     state;
  logic       rise_enter;
  logic       rise_exit;
  logic       sel_onehot;

  // bit order: {sel[2:0], exit, enter}
  assign raw = {sw_sel_raw, btn_exit_raw, btn_enter_raw};

`ifdef PARKING_INPUT_SYNC_EN
  logic [4:0] meta;
  logic [4:0] sync2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta  <= '0;
      sync2 <= '0;
    end else begin
      meta  <= raw;
      sync2 <= meta;
    end
  end

  assign synced = sync2;
`else
  assign synced = raw;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      deb <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (synced[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise_enter = deb[0] & ~btn_d[0];
  assign rise_exit  = deb[1] & ~btn_d[1];
  assign sel_onehot = (deb[4:2] == 3'b001) || (deb[4:2] == 3'b010) || (deb[4:2] == 3'b100);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      btn_d      <= '0;
      enter_pend <= 1'b0;
      exit_pend  <= 1'b0;
      hcnt       <= '0;
      car_enter  <= 1'b0;
      car_exit   <= 1'b0;
      car_sel    <= 3'b000;
      sel_error  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      btn_d     <= deb[1:0];
      car_enter <= 1'b0;
      car_exit  <= 1'b0;
      sel_error <= 1'b0;
      busy      <= (state != IDLE);

      // One-deep pending: a new edge while the flag is still set is dropped.
      if (rise_enter && !enter_pend) enter_pend <= 1'b1;
      else if (state == ISSUE_ENTER) enter_pend <= 1'b0;
      if (rise_exit && !exit_pend) exit_pend <= 1'b1;
      else if (state == ISSUE_EXIT) exit_pend <= 1'b0;

      case (state)
        IDLE: begin
          if (enter_pend) state <= ISSUE_ENTER;
          else if (exit_pend) state <= ISSUE_EXIT;
        end
        ISSUE_ENTER, ISSUE_EXIT: begin
          if (sel_onehot) begin
            car_sel   <= deb[4:2];
            car_enter <= (state == ISSUE_ENTER);
            car_exit  <= (state == ISSUE_EXIT);
          end else begin
            sel_error <= 1'b1;
          end
          hcnt  <= '0;
          state <= HOLDOFF;
        end
        HOLDOFF: begin
          // The IDLE decision is folded into the last holdoff cycle so back-to-back
          // requests are spaced exactly HOLDOFF_CYCLES+1 apart.
          if (hcnt == HOLD_MAX) begin
            hcnt <= '0;
            if (enter_pend) state <= ISSUE_ENTER;
            else if (exit_pend) state <= ISSUE_EXIT;
            else state <= IDLE;
          end else begin
            hcnt <= hcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
